intersection_phase_arbiter: RTL and testbench

- Four-way intersection signal scheduler.
- Shares one green phase among N_APP approaches, one approach at a time, using car-presence sensors.
- Applies minimum and maximum green times, a yellow interval and an all-red clearance interval, and serves waiting approaches in round-robin order.
- Supports a single emergency-preempt input and sits above the per-road light drivers in the traffic FSM library.

---
 rtl/traffic_pkg.sv | 18 +
 rtl/rr_next_sel.sv | 30 +++
 rtl/intersection_phase_arbiter.sv | 151 +++++++++++++++
 tb/tb_intersection_phase_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Light codes and phase encodings shared by the intersection arbiter and the
// highway/country controller.
package traffic_pkg;

   typedef enum logic [1:0] {
      LIGHT_RED    = 2'd0,
      LIGHT_YELLOW = 2'd1,
      LIGHT_GREEN  = 2'd2
   } lightCode_t;

   typedef enum logic [1:0] {
      PH_IDLE   = 2'd0,
      PH_GREEN  = 2'd1,
      PH_YELLOW = 2'd2,
      PH_ALLRED = 2'd3
   } phase_t;

endpackage

// File: rtl/rr_next_sel.sv
// Combinational round-robin picker: first set bit of ereq found by scanning
// upward from ptr, wrapping modulo N_APP.
module rr_next_sel #(
   parameter  int N_APP = 4,
   localparam int AW    = (N_APP > 1) ? $clog2(N_APP) : 1
) (
   input  logic [N_APP-1:0] ereq,
   input  logic [AW-1:0]    ptr,
   output logic [AW-1:0]    sel,
   output logic             any
);

   int w_idx;

   // The first hit wins; later hits in the scan are ignored once any is set.
   always_comb begin
      sel   = '0;
      any   = 1'b0;
      w_idx = 0;
      for (int i = 0; i < N_APP; i++) begin
         w_idx = int'(ptr) + i;
         if (w_idx >= N_APP) w_idx = w_idx - N_APP;
         if (!any && ereq[w_idx]) begin
            any = 1'b1;
            sel = AW'(w_idx);
         end
      end
   end

endmodule

// File: rtl/intersection_phase_arbiter.sv
// Shares one green phase among N_APP approaches with min/max green, yellow,
// all-red clearance, round-robin service and a single emergency preempt.
module intersection_phase_arbiter
   import traffic_pkg::*;
#(
   parameter  int N_APP      = 4,
   parameter  int MIN_GREEN  = 4,
   parameter  int MAX_GREEN  = 12,
   parameter  int YEL_CYC    = 3,
   parameter  int ALLRED_CYC = 2,
   localparam int AW         = (N_APP > 1) ? $clog2(N_APP) : 1
) (
   input  logic               clk,
   input  logic               clear,
   input  logic [N_APP-1:0]   req,
   input  logic               emerg,
   input  logic [AW-1:0]      emerg_app,
   output logic [2*N_APP-1:0] light,
   output logic [AW-1:0]      cur_app,
   output logic [1:0]         phase
);

   localparam int TW = $clog2(MAX_GREEN + YEL_CYC + ALLRED_CYC + 1);

   phase_t             r_phase;
   logic [AW-1:0]      r_curApp;
   logic [AW-1:0]      r_ptr;
   logic [TW-1:0]      r_timer;
   logic [2*N_APP-1:0] r_light;

   logic               w_emergValid;
   logic [N_APP-1:0]   w_emergOneHot;
   logic [N_APP-1:0]   w_curOneHot;
   logic [N_APP-1:0]   w_ereq;
   logic               w_others;
   logic [AW-1:0]      w_nextPtr;
   logic [AW-1:0]      w_pickPtr;
   logic [AW-1:0]      w_rrSel;
   logic [AW-1:0]      w_sel;
   logic               w_any;
   logic               w_preempt;
   logic               w_hold;
   logic               w_normalExit;
   logic               w_greenExit;

   // An out-of-range emergency index can only exist when N_APP is not a power of two.
   generate
      if ((1 << AW) == N_APP) begin : g_fullRange
         assign w_emergValid = emerg;
      end else begin : g_partRange
         assign w_emergValid = emerg && (int'(emerg_app) < N_APP);
      end
   endgenerate

   assign w_emergOneHot = w_emergValid ? (N_APP'(1) << emerg_app) : '0;
   assign w_curOneHot   = N_APP'(1) << r_curApp;
   assign w_ereq        = req | w_emergOneHot;
   assign w_others      = |(w_ereq & ~w_curOneHot);

   // At the end of all-red the search restarts just past the approach that was served.
   assign w_nextPtr = (r_curApp == AW'(N_APP - 1)) ? '0 : r_curApp + AW'(1);
   assign w_pickPtr = (r_phase == PH_ALLRED) ? w_nextPtr : r_ptr;
   assign w_sel     = w_emergValid ? emerg_app : w_rrSel;

   rr_next_sel #(.N_APP(N_APP)) u_rrSel (
      .ereq (w_ereq),
      .ptr  (w_pickPtr),
      .sel  (w_rrSel),
      .any  (w_any)
   );

   assign w_preempt    = w_emergValid && (emerg_app != r_curApp);
   assign w_hold       = w_emergValid && (emerg_app == r_curApp);
   assign w_normalExit = (r_timer >= TW'(MIN_GREEN - 1)) && w_others &&
                         (!w_ereq[r_curApp] || (r_timer == TW'(MAX_GREEN - 1)));
   assign w_greenExit  = w_preempt || (!w_hold && w_normalExit);

   function automatic logic [2*N_APP-1:0] lightFor(input logic [AW-1:0] app,
                                                    input lightCode_t code);
      lightFor = '0;
      for (int i = 0; i < N_APP; i++) begin
         if (AW'(i) == app) lightFor[2*i +: 2] = code;
      end
   endfunction

   // Lights are loaded together with the state so they never lag phase/cur_app.
   always_ff @(posedge clk) begin
      if (clear) begin
         r_phase  <= PH_IDLE;
         r_curApp <= '0;
         r_ptr    <= '0;
         r_timer  <= '0;
         r_light  <= '0;
      end else begin
         case (r_phase)
            PH_IDLE: begin
               if (w_any) begin
                  r_phase  <= PH_GREEN;
                  r_curApp <= w_sel;
                  r_timer  <= '0;
                  r_light  <= lightFor(w_sel, LIGHT_GREEN);
               end
            end
            PH_GREEN: begin
               if (w_greenExit) begin
                  r_phase <= PH_YELLOW;
                  r_timer <= '0;
                  r_light <= lightFor(r_curApp, LIGHT_YELLOW);
               end else if (r_timer != TW'(MAX_GREEN - 1)) begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            PH_YELLOW: begin
               if (r_timer == TW'(YEL_CYC - 1)) begin
                  r_phase <= PH_ALLRED;
                  r_timer <= '0;
                  r_light <= '0;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            PH_ALLRED: begin
               if (r_timer == TW'(ALLRED_CYC - 1)) begin
                  r_ptr   <= w_nextPtr;
                  r_timer <= '0;
                  if (w_any) begin
                     r_phase  <= PH_GREEN;
                     r_curApp <= w_sel;
                     r_light  <= lightFor(w_sel, LIGHT_GREEN);
                  end else begin
                     r_phase <= PH_IDLE;
                     r_light <= '0;
                  end
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            default: begin
               r_phase <= PH_IDLE;
               r_timer <= '0;
               r_light <= '0;
            end
         endcase
      end
   end

   assign light   = r_light;
   assign cur_app = r_curApp;
   assign phase   = r_phase;

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Bench for intersection_phase_arbiter: behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_intersection_phase_arbiter;

   localparam int N_APP      = 4;
   localparam int MIN_GREEN  = 4;
   localparam int MAX_GREEN  = 12;
   localparam int YEL_CYC    = 3;
   localparam int ALLRED_CYC = 2;

   logic       clk;
   logic       clear;
   logic [3:0] req;
   logic       emerg;
   logic [1:0] emerg_app;
   logic [7:0] light;
   logic [1:0] cur_app;
   logic [1:0] phase;

   int nChecks = 0;
   int nPass   = 0;

   intersection_phase_arbiter #(
      .N_APP(N_APP), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
      .YEL_CYC(YEL_CYC), .ALLRED_CYC(ALLRED_CYC)
   ) dut (
      .clk       (clk),
      .clear     (clear),
      .req       (req),
      .emerg     (emerg),
      .emerg_app (emerg_app),
      .light     (light),
      .cur_app   (cur_app),
      .phase     (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   // Model: mPhase 0..3 (idle/green/yellow/allred), mServed counts green
   // cycles shown so far, mLeft counts cycles still to show in yellow/allred.
   int mPhase = 0;
   int mCur = 0;
   int mPtr = 0;
   int mServed = 0;
   int mLeft = 0;

   function automatic int pickNext(input logic [3:0] er, input int from, input bit ev);
      if (ev) return int'(emerg_app);
      for (int k = 0; k < N_APP; k++) begin
         if (er[(from + k) % N_APP]) return (from + k) % N_APP;
      end
      return 0;
   endfunction

   task automatic modelStep();
      logic [3:0] er;
      bit ev;
      bit leave;
      bit othersWait;
      if (clear) begin
         mPhase = 0; mCur = 0; mPtr = 0; mServed = 0; mLeft = 0;
         return;
      end
      ev = emerg && (int'(emerg_app) < N_APP);
      er = req | (ev ? (4'b0001 << emerg_app) : 4'b0000);
      case (mPhase)
         0: if (er != 0) begin
               mCur = pickNext(er, mPtr, ev); mPhase = 1; mServed = 1;
            end
         1: begin
               othersWait = (er & ~(4'b0001 << mCur)) != 0;
               if (ev) leave = (int'(emerg_app) != mCur);
               else leave = othersWait && (mServed >= MIN_GREEN) &&
                            (!er[mCur] || mServed >= MAX_GREEN);
               if (leave) begin mPhase = 2; mLeft = YEL_CYC; end
               else mServed++;
            end
         2: begin
               mLeft--;
               if (mLeft == 0) begin mPhase = 3; mLeft = ALLRED_CYC; end
            end
         default: begin
               mLeft--;
               if (mLeft == 0) begin
                  mPtr = (mCur + 1) % N_APP;
                  if (er != 0) begin
                     mCur = pickNext(er, mPtr, ev); mPhase = 1; mServed = 1;
                  end else begin
                     mPhase = 0;
                  end
               end
            end
      endcase
   endtask

   always @(posedge clk) modelStep();

   task automatic checkOutput();
      logic [7:0] expLight;
      int nonRed;
      expLight = '0;
      if (mPhase == 1) expLight[2*mCur +: 2] = 2'd2;
      else if (mPhase == 2) expLight[2*mCur +: 2] = 2'd1;
      check("modelPhase", phase, mPhase);
      check("modelLight", light, expLight);
      check("modelCurApp", cur_app, mCur);
      nonRed = 0;
      for (int i = 0; i < N_APP; i++) if (light[2*i +: 2] != 2'd0) nonRed++;
      nChecks++;
      assert (nonRed <= 1) nPass++;
      else $display("[TB] FAIL oneHotNonRed: got %0d non-red approaches, required at most 1", nonRed);
   endtask

   always @(posedge clk) begin
      #1;
      checkOutput();
   end

   task automatic applyStimulus(input logic [3:0] r, input logic e, input logic [1:0] a,
                                input logic c, input int nCycles);
      req = r; emerg = e; emerg_app = a; clear = c;
      repeat (nCycles) @(negedge clk);
   endtask

   task automatic measureRun(input logic [7:0] pat, output int n);
      n = 0;
      while (light == pat && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic waitPhase(input logic [1:0] ph, output bit ok);
      int n;
      n = 0;
      while (phase != ph && n < 100) begin
         n++;
         @(negedge clk);
      end
      ok = (phase == ph);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n, y, a, who;
      bit ok;
      logic [3:0] rq;
      logic em;
      logic [1:0] ea;
      req = '0; emerg = 1'b0; emerg_app = '0; clear = 1'b1;
      @(negedge clk);

      $display("[TB] single requester");
      applyStimulus(4'b0000, 0, 0, 1, 2);
      check("resetPhase", phase, 0);
      check("resetLight", light, 8'h00);
      check("resetCurApp", cur_app, 0);
      applyStimulus(4'b0001, 0, 0, 0, 1);
      check("singleGrantLight", light, 8'h02);
      check("singleGrantPhase", phase, 1);
      applyStimulus(4'b0001, 0, 0, 0, 2);
      applyStimulus(4'b0000, 0, 0, 0, 20);
      check("restLight", light, 8'h02);
      check("restPhase", phase, 1);
      check("restCurApp", cur_app, 0);

      $display("[TB] max green cutoff");
      applyStimulus(4'b0000, 0, 0, 1, 1);
      applyStimulus(4'b0001, 0, 0, 0, 1);
      applyStimulus(4'b0101, 0, 0, 0, 0);
      measureRun(8'h02, n);
      check("maxGreenLen", n, 12);
      measureRun(8'h01, n);
      check("maxYellowLen", n, 3);
      measureRun(8'h00, n);
      check("maxAllRedLen", n, 2);
      check("maxNextCur", cur_app, 2);
      check("maxNextLight", light, 8'h20);

      $display("[TB] min green");
      applyStimulus(4'b0000, 0, 0, 1, 1);
      applyStimulus(4'b0011, 0, 0, 0, 2);
      applyStimulus(4'b0010, 0, 0, 0, 0);
      measureRun(8'h02, n);
      check("minGreenLen", n + 1, 4);
      measureRun(8'h01, n);
      check("minYellowLen", n, 3);
      measureRun(8'h00, n);
      check("minAllRedLen", n, 2);
      check("minNextLight", light, 8'h08);

      $display("[TB] fairness");
      applyStimulus(4'b0000, 0, 0, 1, 1);
      applyStimulus(4'b1111, 0, 0, 0, 1);
      for (int k = 0; k < 4; k++) begin
         check("fairOrder", cur_app, k);
         who = int'(cur_app);
         measureRun(8'h02 << (2*who), n);
         check("fairGreenLen", n, 12);
         measureRun(8'h01 << (2*who), y);
         measureRun(8'h00, a);
         check("fairGap", y + a, 5);
      end
      check("fairWrap", cur_app, 0);

      $display("[TB] emergency preempt");
      applyStimulus(4'b0000, 0, 0, 1, 1);
      applyStimulus(4'b0001, 0, 0, 0, 2);
      applyStimulus(4'b0001, 1, 3, 0, 1);
      check("preemptPhase", phase, 2);
      measureRun(8'h01, n);
      check("preemptYellowLen", n, 3);
      measureRun(8'h00, n);
      check("preemptAllRedLen", n, 2);
      check("preemptCur", cur_app, 3);
      check("preemptLight", light, 8'h80);
      applyStimulus(4'b0111, 1, 3, 0, 30);
      check("preemptHoldCur", cur_app, 3);
      check("preemptHoldPhase", phase, 1);
      applyStimulus(4'b0111, 0, 0, 0, 10);

      $display("[TB] mid-operation reset");
      applyStimulus(4'b0000, 0, 0, 1, 1);
      applyStimulus(4'b0011, 0, 0, 0, 0);
      waitPhase(2'd2, ok);
      check("reachYellow", ok, 1);
      applyStimulus(4'b0011, 0, 0, 1, 1);
      check("midResetPhase", phase, 0);
      check("midResetLight", light, 8'h00);
      check("midResetCur", cur_app, 0);
      applyStimulus(4'b0100, 0, 0, 0, 1);
      check("postResetLight", light, 8'h20);
      check("postResetCur", cur_app, 2);

      $display("[TB] randomized traffic");
      rq = 4'b0000; em = 1'b0; ea = 2'd0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 7) == 0) rq = 4'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            em = ~em;
            ea = 2'($urandom);
         end
         applyStimulus(rq, em, ea, ($urandom_range(0, 499) == 0), 1);
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
